// File: rtl/user_io.sv
// Front-panel controller: turns switches and pushbuttons into cursor moves,
// note selection, and writes/deletes on a 40-slot composition of 6-bit notes.
module user_io #(
    parameter int unsigned DEPTH    = 40,
    parameter int unsigned NOTE_MAX = 35
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SW0,
    input  logic       SW1,
    input  logic       KEY0,
    input  logic       KEY1,
    input  logic       KEY2,
    input  logic       KEY3,
    output logic [5:0] note_RAM [DEPTH-1:0],
    output logic [5:0] i_note,
    output logic [5:0] pos_out,
    output logic [5:0] note_out,
    output logic       confirm,
    output logic       delete,
    output logic       write_en,
    output logic [6:0] HEX3,
    output logic [6:0] HEX2,
    output logic [6:0] HEX1
);

    localparam logic [5:0] LAST = 6'(DEPTH - 1);
    localparam logic [5:0] NMAX = 6'(NOTE_MAX);

    logic [3:0] key_vec;
    logic [3:0] key_prev;
    logic [3:0] press;
    logic       act_del;
    logic       act_conf;
    logic       act_inc;
    logic       act_dec;
    logic       del_ok;
    logic [5:0] cap;
    logic [5:0] del_idx;
    logic [5:0] pos_tens;
    logic [5:0] pos_ones;
    logic [5:0] note_mod;

    assign key_vec = {KEY3, KEY2, KEY1, KEY0};
    assign press   = key_prev & ~key_vec;

    // One action per cycle, priority KEY0 > KEY1 > KEY3 > KEY2; lock masks all.
    always_comb begin
        act_del  = ~SW1 & press[0];
        act_conf = ~SW1 & ~press[0] & press[1];
        act_inc  = ~SW1 & ~press[0] & ~press[1] & press[3];
        act_dec  = ~SW1 & ~press[0] & ~press[1] & ~press[3] & press[2];
        del_ok   = act_del & (i_note != 6'd0);
        cap      = (i_note < LAST) ? i_note : LAST;
        del_idx  = (pos_out < i_note) ? pos_out : i_note - 6'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                note_RAM[i] <= '0;
            end
            i_note   <= '0;
            pos_out  <= '0;
            note_out <= '0;
            confirm  <= 1'b0;
            delete   <= 1'b0;
            write_en <= 1'b0;
            key_prev <= '1;
        end else begin
            key_prev <= key_vec;
            confirm  <= act_conf;
            delete   <= del_ok;
            write_en <= act_conf | del_ok;
            if (act_conf) begin
                note_RAM[pos_out] <= note_out;
                if (pos_out == i_note) begin
                    i_note <= i_note + 6'd1;
                    if (pos_out < LAST) begin
                        pos_out <= pos_out + 6'd1;
                    end
                end
            end else if (del_ok) begin
                for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                    if (i >= 32'(del_idx)) begin
                        note_RAM[i] <= note_RAM[i + 1];
                    end
                end
                note_RAM[DEPTH - 1] <= '0;
                i_note <= i_note - 6'd1;
                if (pos_out > i_note - 6'd1) begin
                    pos_out <= i_note - 6'd1;
                end
            end else if (act_inc) begin
                if (SW0) begin
                    note_out <= (note_out < NMAX) ? note_out + 6'd1 : note_out;
                end else begin
                    pos_out <= (pos_out < cap) ? pos_out + 6'd1 : pos_out;
                end
            end else if (act_dec) begin
                if (SW0) begin
                    note_out <= (note_out != 6'd0) ? note_out - 6'd1 : note_out;
                end else begin
                    pos_out <= (pos_out != 6'd0) ? pos_out - 6'd1 : pos_out;
                end
            end
        end
    end

    // Active-low segments {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0:    seg7 = 7'h40;
            4'h1:    seg7 = 7'h79;
            4'h2:    seg7 = 7'h24;
            4'h3:    seg7 = 7'h30;
            4'h4:    seg7 = 7'h19;
            4'h5:    seg7 = 7'h12;
            4'h6:    seg7 = 7'h02;
            4'h7:    seg7 = 7'h78;
            4'h8:    seg7 = 7'h00;
            4'h9:    seg7 = 7'h10;
            4'ha:    seg7 = 7'h08;
            4'hb:    seg7 = 7'h03;
            default: seg7 = 7'h7f;
        endcase
    endfunction

    always_comb begin
        pos_tens = pos_out / 6'd10;
        pos_ones = pos_out % 6'd10;
        note_mod = note_out % 6'd12;
        HEX3     = seg7(pos_tens[3:0]);
        HEX2     = seg7(pos_ones[3:0]);
        HEX1     = seg7(note_mod[3:0]);
    end

endmodule

// File: tb/tb_user_io.sv
// Directed bench for user_io: a table of key presses with hand-computed
// resulting state, plus sequences for fill/saturation, delete-at-end and reset.
module tb_user_io;

    logic       clk = 1'b0;
    logic       reset;
    logic       SW0, SW1, KEY0, KEY1, KEY2, KEY3;
    logic [5:0] note_ram [39:0];
    logic [5:0] i_note, pos_out, note_out;
    logic       confirm, delete, write_en;
    logic [6:0] HEX3, HEX2, HEX1;

    int checks   = 0;
    int failures = 0;

    user_io #(.DEPTH(40), .NOTE_MAX(35)) dut (
        .clk(clk), .reset(reset),
        .SW0(SW0), .SW1(SW1),
        .KEY0(KEY0), .KEY1(KEY1), .KEY2(KEY2), .KEY3(KEY3),
        .note_RAM(note_ram),
        .i_note(i_note), .pos_out(pos_out), .note_out(note_out),
        .confirm(confirm), .delete(delete), .write_en(write_en),
        .HEX3(HEX3), .HEX2(HEX2), .HEX1(HEX1)
    );

    always #5 clk = ~clk;

    // press: bit0 KEY0 delete, bit1 KEY1 confirm, bit2 KEY2 dec, bit3 KEY3 inc
    // pulses: {confirm, delete, write_en} seen right after the press edge
    typedef struct {
        logic [1:0] sw;
        logic [3:0] press;
        logic [2:0] pulses;
        logic [5:0] e_i;
        logic [5:0] e_pos;
        logic [5:0] e_note;
        int         ram_idx;
        logic [5:0] ram_val;
    } vec_t;

    vec_t vecs [34];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_press(input logic [1:0] sw, input logic [3:0] mask,
                            output logic [2:0] p1, output logic [2:0] p2);
        {SW1, SW0} = sw;
        {KEY3, KEY2, KEY1, KEY0} = ~mask;
        @(posedge clk); #1;
        p1 = {confirm, delete, write_en};
        {KEY3, KEY2, KEY1, KEY0} = 4'hf;
        @(posedge clk); #1;
        p2 = {confirm, delete, write_en};
    endtask

    function automatic vec_t mk(input logic [1:0] sw, input logic [3:0] pr,
                                input logic [2:0] pu, input int ei, input int ep,
                                input int en, input int ri, input int rv);
        vec_t v;
        v.sw = sw; v.press = pr; v.pulses = pu;
        v.e_i = 6'(ei); v.e_pos = 6'(ep); v.e_note = 6'(en);
        v.ram_idx = ri; v.ram_val = 6'(rv);
        return v;
    endfunction

    initial begin
        logic [2:0] p1, p2;
        int         nz;

        vecs[0]  = mk(2'b01, 4'b0100, 3'b000, 0, 0, 0, 0, 0);
        vecs[1]  = mk(2'b01, 4'b1000, 3'b000, 0, 0, 1, 0, 0);
        vecs[2]  = mk(2'b01, 4'b1000, 3'b000, 0, 0, 2, 0, 0);
        vecs[3]  = mk(2'b01, 4'b1000, 3'b000, 0, 0, 3, 0, 0);
        vecs[4]  = mk(2'b01, 4'b1000, 3'b000, 0, 0, 4, 0, 0);
        vecs[5]  = mk(2'b01, 4'b1000, 3'b000, 0, 0, 5, 0, 0);
        vecs[6]  = mk(2'b01, 4'b0010, 3'b101, 1, 1, 5, 0, 5);
        vecs[7]  = mk(2'b00, 4'b0100, 3'b000, 1, 0, 5, 0, 5);
        vecs[8]  = mk(2'b01, 4'b1000, 3'b000, 1, 0, 6, 0, 5);
        vecs[9]  = mk(2'b01, 4'b0010, 3'b101, 1, 0, 6, 0, 6);
        vecs[10] = mk(2'b00, 4'b1000, 3'b000, 1, 1, 6, 0, 6);
        vecs[11] = mk(2'b00, 4'b1000, 3'b000, 1, 1, 6, 1, 0);
        vecs[12] = mk(2'b00, 4'b0100, 3'b000, 1, 0, 6, 0, 6);
        vecs[13] = mk(2'b01, 4'b0100, 3'b000, 1, 0, 5, 0, 6);
        vecs[14] = mk(2'b01, 4'b0010, 3'b101, 1, 0, 5, 0, 5);
        vecs[15] = mk(2'b00, 4'b1000, 3'b000, 1, 1, 5, 0, 5);
        vecs[16] = mk(2'b01, 4'b1000, 3'b000, 1, 1, 6, 0, 5);
        vecs[17] = mk(2'b01, 4'b0010, 3'b101, 2, 2, 6, 1, 6);
        vecs[18] = mk(2'b01, 4'b1000, 3'b000, 2, 2, 7, 1, 6);
        vecs[19] = mk(2'b01, 4'b0010, 3'b101, 3, 3, 7, 2, 7);
        vecs[20] = mk(2'b00, 4'b0100, 3'b000, 3, 2, 7, 2, 7);
        vecs[21] = mk(2'b00, 4'b0100, 3'b000, 3, 1, 7, 1, 6);
        vecs[22] = mk(2'b00, 4'b0001, 3'b011, 2, 1, 7, 1, 7);
        vecs[23] = mk(2'b10, 4'b0001, 3'b000, 2, 1, 7, 0, 5);
        vecs[24] = mk(2'b10, 4'b0010, 3'b000, 2, 1, 7, 2, 0);
        vecs[25] = mk(2'b10, 4'b0100, 3'b000, 2, 1, 7, 1, 7);
        vecs[26] = mk(2'b10, 4'b1000, 3'b000, 2, 1, 7, 0, 5);
        vecs[27] = mk(2'b11, 4'b1000, 3'b000, 2, 1, 7, 1, 7);
        vecs[28] = mk(2'b00, 4'b0011, 3'b011, 1, 1, 7, 1, 0);
        vecs[29] = mk(2'b00, 4'b0001, 3'b011, 0, 0, 7, 0, 0);
        vecs[30] = mk(2'b00, 4'b0001, 3'b000, 0, 0, 7, 0, 0);
        vecs[31] = mk(2'b01, 4'b1100, 3'b000, 0, 0, 8, 0, 0);
        vecs[32] = mk(2'b01, 4'b1010, 3'b101, 1, 1, 8, 0, 8);
        vecs[33] = mk(2'b00, 4'b1000, 3'b000, 1, 1, 8, 0, 8);

        reset = 1'b1;
        {SW1, SW0} = 2'b00;
        {KEY3, KEY2, KEY1, KEY0} = 4'hf;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_i_note", i_note, 0);
        check("reset_pos", pos_out, 0);
        check("reset_note", note_out, 0);
        check("reset_pulses", {confirm, delete, write_en}, 0);
        check("reset_hex3", HEX3, 7'h40);
        check("reset_hex2", HEX2, 7'h40);
        check("reset_hex1", HEX1, 7'h40);
        nz = 0;
        for (int i = 0; i < 40; i++) if (note_ram[i] != 6'd0) nz++;
        check("reset_ram_nonzero", nz, 0);

        for (int k = 0; k < 34; k++) begin
            do_press(vecs[k].sw, vecs[k].press, p1, p2);
            check($sformatf("v%0d_pulses", k), p1, vecs[k].pulses);
            check($sformatf("v%0d_pulses_after", k), p2, 0);
            check($sformatf("v%0d_i_note", k), i_note, vecs[k].e_i);
            check($sformatf("v%0d_pos", k), pos_out, vecs[k].e_pos);
            check($sformatf("v%0d_note", k), note_out, vecs[k].e_note);
            check($sformatf("v%0d_ram%0d", k, vecs[k].ram_idx),
                  note_ram[vecs[k].ram_idx], vecs[k].ram_val);
        end

        // Holding a key yields one action only
        {SW1, SW0} = 2'b01;
        {KEY3, KEY2, KEY1, KEY0} = 4'b0111;
        repeat (4) @(posedge clk);
        #1 {KEY3, KEY2, KEY1, KEY0} = 4'hf;
        @(posedge clk); #1;
        check("hold_note", note_out, 9);

        // Note saturates at 35, shown as 'b'
        for (int k = 0; k < 40; k++) do_press(2'b01, 4'b1000, p1, p2);
        check("note_sat", note_out, 35);
        check("hex1_b", HEX1, 7'h03);

        // Fill to 40 entries (starts at i_note=1, pos=1)
        for (int k = 0; k < 39; k++) do_press(2'b01, 4'b0010, p1, p2);
        check("fill_i_note", i_note, 40);
        check("fill_pos", pos_out, 39);
        check("fill_hex3", HEX3, 7'h30);
        check("fill_hex2", HEX2, 7'h10);
        do_press(2'b00, 4'b1000, p1, p2);
        check("nav_sat_pos", pos_out, 39);
        do_press(2'b01, 4'b0010, p1, p2);
        check("full_conf_pulses", p1, 3'b101);
        check("full_conf_i_note", i_note, 40);
        check("full_conf_ram39", note_ram[39], 35);

        // Delete the last slot of a full composition
        do_press(2'b00, 4'b0001, p1, p2);
        check("del_end_pulses", p1, 3'b011);
        check("del_end_i_note", i_note, 39);
        check("del_end_pos", pos_out, 39);
        check("del_end_ram39", note_ram[39], 0);
        check("del_end_ram38", note_ram[38], 35);
        check("del_end_ram0", note_ram[0], 8);

        // Reset coinciding with a confirm press wins
        {SW1, SW0} = 2'b01;
        KEY1  = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        KEY1  = 1'b1;
        check("rst_win_i_note", i_note, 0);
        check("rst_win_pos", pos_out, 0);
        check("rst_win_note", note_out, 0);
        check("rst_win_confirm", confirm, 0);
        check("rst_win_ram0", note_ram[0], 0);
        @(posedge clk); #1;
        check("rst_win_pulses_next", {confirm, delete, write_en}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/user_io.md
Name: user_io

Overview:
- Front-panel controller for the FPGA music composer.
- Turns DE1 switches and pushbuttons into edits of a 40-entry composition of 6-bit notes: cursor movement, note selection, write and delete.
- Holds the composition register file, a cursor (pos_out), the valid-length bound (i_note) and the selected note (note_out), and drives three 7-segment displays.
- Downstream playback logic reads note_RAM and i_note.

Parameters:
- DEPTH, 40, number of composition slots.
- NOTE_MAX, 35, largest selectable note value (3 octaves x 12 semitones).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- SW0  input  1  mode switch, low bit.
- SW1  input  1  mode switch, high bit; 1 = edit lock.
- KEY0  input  1  active-low pushbutton: delete.
- KEY1  input  1  active-low pushbutton: confirm (write).
- KEY2  input  1  active-low pushbutton: decrement.
- KEY3  input  1  active-low pushbutton: increment.
- note_RAM  output  6 x 40 (unpacked [39:0] of [5:0])  composition storage.
- i_note  output  6  number of valid notes, 0..40; valid indices are 0..i_note-1.
- pos_out  output  6  cursor index, 0..min(i_note,39).
- note_out  output  6  currently selected note value, 0..NOTE_MAX.
- confirm  output  1  one-cycle pulse on an accepted write.
- delete  output  1  one-cycle pulse on an accepted delete.
- write_en  output  1  one-cycle pulse whenever note_RAM changes.
- HEX3  output  7  active-low segments {g..a}: pos_out tens digit.
- HEX2  output  7  active-low segments: pos_out ones digit.
- HEX1  output  7  active-low segments: note_out mod 12, shown as hex digit 0..b.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values:
  - all note_RAM entries 0; i_note=0; pos_out=0; note_out=0.
  - confirm, delete, write_en = 0.
  - key-history registers = 1 (released), so no press is detected on the first cycle after reset.
- Inputs are synchronous to clk; no debouncing is performed.
- Press detection:
  - press_k = prev_KEYk & ~KEYk, where prev_KEYk is KEYk registered each cycle.
  - The action takes effect at the same rising edge where KEYk is first sampled low, so outputs update one edge after the press.
  - Holding a key produces exactly one action.
- Priority: at most one action per cycle, in the order KEY0 > KEY1 > KEY3 > KEY2. Lower-priority presses in that cycle are discarded.
- SW1=1 (lock): all presses are ignored; state holds; pulses stay 0.
- SW1=0, SW0=0 (navigate):
  - KEY3: pos_out+1, saturating at min(i_note,39).
  - KEY2: pos_out-1, saturating at 0.
- SW1=0, SW0=1 (select):
  - KEY3: note_out+1, saturating at NOTE_MAX.
  - KEY2: note_out-1, saturating at 0.
- KEY1 confirm, in either unlocked mode:
  - note_RAM[pos_out] <= note_out; confirm=1 and write_en=1 for one cycle.
  - If pos_out==i_note (append): i_note+1, and pos_out+1 if pos_out<39.
  - If i_note==40: the write overwrites the slot; i_note stays 40.
- KEY0 delete, in either unlocked mode:
  - If i_note==0: ignored, no pulses.
  - Otherwise let d = pos_out if pos_out<i_note, else i_note-1.
  - Entries d+1..39 shift down by one; entry 39 becomes 0; i_note-1.
  - pos_out becomes min(pos_out, new i_note); it never exceeds 39.
  - delete=1 and write_en=1 for one cycle.
- Pulses are registered: high exactly the one cycle following the accepted press edge.
- Reset mid-operation wins over any action in the same cycle.
- HEX encoding is combinational from pos_out/note_out. Standard 0-9, A, b glyphs; segment bit 0 = a, bit 6 = g; 0 = lit.

Test Plan:
- Reset, then all keys released for 3 cycles -> i_note=0, pos_out=0, note_out=0, all pulses 0, HEX3/HEX2 show "00".
- SW=01, press KEY3 5 times (release between presses), press KEY1 -> note_out=5; note_RAM[0]=5; i_note=1; pos_out=1; confirm and write_en each high exactly 1 cycle.
- SW=00, press KEY2 once, SW=01, press KEY3 once, press KEY1 -> note_RAM[0]=6; i_note stays 1; pos_out=0 (cursor stays on an overwrite).
- Append 40 notes, then press KEY3 in navigate mode -> i_note=40; pos_out saturates at 39; HEX3/HEX2 show "39"; a further confirm leaves i_note=40.
- With notes [5,6,7] (i_note=3), pos_out=1, press KEY0 -> note_RAM[0..2]=[5,7,0]; i_note=2; pos_out=1; delete pulses 1 cycle; a second delete at i_note=0 does nothing.
- SW1=1, press each key -> no state change; KEY1 and KEY0 pressed in the same cycle when unlocked -> only the delete executes.
